// File: rtl/my_ff_mac_stream_ctrl_pkg.sv
// Shared definitions for the two-term floating-point MAC stream shell.
// Holds the word width, the datapath latency and the operand tuple layout.
package my_ff_pkg;

  localparam int DATA_W      = 32;
  localparam int MAC_LATENCY = 18;  // two chained 9-cycle MAC stages

  typedef logic [DATA_W-1:0] ff_word_t;

  typedef struct packed {
    ff_word_t c;
    ff_word_t a0;
    ff_word_t b0;
    ff_word_t a1;
    ff_word_t b1;
  } ff_mac_operands_t;

endpackage

// File: rtl/my_ff_mac_stream_ctrl_if.sv
// Bus bundle of the MAC stream shell: upstream operand stream, datapath
// issue/return path, downstream result stream and the credit count.
//   slave  : the shell (my_ff_mac_stream_ctrl)
//   master : the environment (producer, datapath and consumer)
// Word width is my_ff_pkg::DATA_W; credits is $clog2(FIFO_DEPTH)+1 bits.
interface my_ff_mac_stream_ctrl_if #(
  parameter int FIFO_DEPTH = 32
);
  import my_ff_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          s_valid;
  logic          s_ready;
  ff_word_t      s_c, s_a0, s_b0, s_a1, s_b1;

  logic          dp_valid;
  ff_word_t      dp_c, dp_a0, dp_b0, dp_a1, dp_b1;
  ff_word_t      dp_result;

  logic          m_valid;
  logic          m_ready;
  ff_word_t      m_data;

  logic [CW-1:0] credits;

  modport slave (
    input  s_valid, s_c, s_a0, s_b0, s_a1, s_b1,
    output s_ready,
    output dp_valid, dp_c, dp_a0, dp_b0, dp_a1, dp_b1,
    input  dp_result,
    output m_valid, m_data,
    input  m_ready,
    output credits
  );

  modport master (
    output s_valid, s_c, s_a0, s_b0, s_a1, s_b1,
    input  s_ready,
    input  dp_valid, dp_c, dp_a0, dp_b0, dp_a1, dp_b1,
    output dp_result,
    input  m_valid, m_data,
    output m_ready,
    input  credits
  );

endinterface

// File: rtl/my_ff_mac_stream_ctrl_fifo.sv
// my_ff_sync_fifo: first-word-fall-through synchronous FIFO.
//   clock, areset       : rising-edge clock, async active-high reset
//   push, push_data     : write request and data
//   pop, pop_data       : read request; pop_data shows the head, 0 when empty
//   full, empty, count  : status; count is 0..DEPTH
// DEPTH must be a power of two >= 2. Pointers carry one extra MSB so that
// full and empty are told apart. Storage is not reset.
module my_ff_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic                   clock,
  input  logic                   areset,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count    = wr_ptr - rd_ptr;
  assign do_pop   = pop && !empty;
  // A write into a full FIFO is allowed only when the head leaves in the same cycle.
  assign do_push  = push && (!full || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clock) disable iff (areset)
    !(push && full && !pop));

endmodule

// File: rtl/my_ff_mac_stream_ctrl.sv
// Flow-control shell for the fixed-latency two-term FP MAC datapath.
//   clock, areset : rising-edge clock, async active-high reset
//   bus.s_*       : upstream operand tuple stream (valid/ready)
//   bus.dp_*      : registered issue toward the datapath, dp_result back
//   bus.m_*       : downstream result stream (valid/ready, FWFT)
//   bus.credits   : result slots neither buffered nor in flight
// A tuple is issued only against a free credit, so every result returning
// LATENCY cycles later is guaranteed a FIFO slot.
module my_ff_mac_stream_ctrl
  import my_ff_pkg::*;
#(
  parameter int LATENCY    = MAC_LATENCY,
  parameter int FIFO_DEPTH = 32
) (
  input logic                    clock,
  input logic                    areset,
  my_ff_mac_stream_ctrl_if.slave bus
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [CW-1:0]    credits;
  logic             accept, pop;
  ff_mac_operands_t issue_q;
  logic             issue_v;
  logic [LATENCY-1:0] track;
  logic             fifo_full, fifo_empty;
  logic [AW:0]      fifo_count;
  ff_word_t         fifo_head;

  assign bus.s_ready = (credits != '0) && !areset;
  assign accept      = bus.s_valid && bus.s_ready;
  assign pop         = !fifo_empty && bus.m_ready;

  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      credits <= CW'(FIFO_DEPTH);
    end else if (accept && !pop) begin
      credits <= credits - CW'(1);
    end else if (pop && !accept) begin
      credits <= credits + CW'(1);
    end
  end

  // Issue register: operands hold their last value between accepts.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      issue_q <= '0;
      issue_v <= 1'b0;
    end else begin
      issue_v <= accept;
      if (accept) issue_q <= {bus.s_c, bus.s_a0, bus.s_b0, bus.s_a1, bus.s_b1};
    end
  end

  // Mirrors the datapath pipeline; the last stage marks dp_result as live.
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      track <= '0;
    end else begin
      track[0] <= issue_v;
      for (int i = 1; i < LATENCY; i++) track[i] <= track[i-1];
    end
  end

  my_ff_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .areset    (areset),
    .push      (track[LATENCY-1]),
    .push_data (bus.dp_result),
    .pop       (pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.dp_valid = issue_v;
  assign bus.dp_c     = issue_q.c;
  assign bus.dp_a0    = issue_q.a0;
  assign bus.dp_b0    = issue_q.b0;
  assign bus.dp_a1    = issue_q.a1;
  assign bus.dp_b1    = issue_q.b1;
  assign bus.m_valid  = !fifo_empty;
  assign bus.m_data   = fifo_head;
  assign bus.credits  = credits;

  a_result_has_slot: assert property (@(posedge clock) disable iff (areset)
    !(track[LATENCY-1] && fifo_full && !pop));

  a_credit_bound: assert property (@(posedge clock) disable iff (areset)
    ((CW+1)'(credits) + (CW+1)'(fifo_count)) <= (CW+1)'(FIFO_DEPTH));

endmodule

// File: tb/tb_my_ff_mac_stream_ctrl.sv
// Self-checking bench for my_ff_mac_stream_ctrl. A behavioural datapath
// (real arithmetic, LATENCY-deep delay) closes the loop; a queue-based
// scoreboard predicts handshakes, credits, occupancy and result order.
module tb_my_ff_mac_stream_ctrl;
  import my_ff_pkg::*;

  localparam int LAT = MAC_LATENCY;
  localparam int FD  = 32;

  logic clock = 1'b0;
  logic areset;
  always #5 clock = ~clock;

  my_ff_mac_stream_ctrl_if #(.FIFO_DEPTH(FD)) bus ();

  my_ff_mac_stream_ctrl #(.LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .clock  (clock),
    .areset (areset),
    .bus    (bus)
  );

  function automatic real f32_to_real(input ff_word_t w);
    real m;
    int  e;
    e = int'(w[30:23]);
    if (e == 0) return 0.0;
    m = (1.0 + real'(w[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return w[31] ? -m : m;
  endfunction

  function automatic ff_word_t real_to_f32(input real r);
    real a;
    int  e;
    int  mant;
    logic s;
    if (r == 0.0) return '0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    mant = int'((a - 1.0) * 8388608.0);
    return {s, 8'(e + 127), 23'(mant)};
  endfunction

  function automatic ff_word_t mac_ref(input ff_mac_operands_t o);
    return real_to_f32(f32_to_real(o.c) + f32_to_real(o.a0) * f32_to_real(o.b0)
                       + f32_to_real(o.a1) * f32_to_real(o.b1));
  endfunction

  // Behavioural datapath: result appears LAT cycles after the operands.
  ff_word_t dp_pipe [LAT];
  always @(posedge clock) begin
    ff_mac_operands_t o;
    o = {bus.dp_c, bus.dp_a0, bus.dp_b0, bus.dp_a1, bus.dp_b1};
    dp_pipe[0] <= mac_ref(o);
    for (int i = 1; i < LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
  end
  assign bus.dp_result = dp_pipe[LAT-1];

  typedef struct {
    ff_word_t data;
    int       avail;
  } sb_t;

  sb_t              sb_q [$];
  int               cyc = 0;
  int               n_checks = 0;
  int               n_fail = 0;
  int               n_accepts = 0;
  int               min_credits;
  int               first_mv_cyc;
  ff_word_t         first_md;
  logic             prev_accept = 1'b0;
  ff_mac_operands_t last_ops = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic ff_word_t int_f32(input int v);
    return real_to_f32(real'(v));
  endfunction

  task automatic set_tuple(input ff_word_t c, a0, b0, a1, b1);
    bus.s_c = c; bus.s_a0 = a0; bus.s_b0 = b0; bus.s_a1 = a1; bus.s_b1 = b1;
  endtask

  task automatic rand_tuple();
    set_tuple(int_f32($urandom_range(0, 15)), int_f32($urandom_range(0, 15)),
              int_f32($urandom_range(0, 15)), int_f32($urandom_range(0, 15)),
              int_f32($urandom_range(0, 15)));
  endtask

  // One clock cycle: compare at the falling edge, advance the model at the rising edge.
  task automatic tick();
    int               occ;
    int               exp_cred;
    logic             exp_rdy, exp_mv, acc, pp;
    ff_word_t         exp_md;
    ff_mac_operands_t ops;
    @(negedge clock);
    if (areset) begin
      sb_q.delete();
      prev_accept = 1'b0;
      last_ops    = '0;
    end
    exp_cred = FD - sb_q.size();
    exp_rdy  = !areset && (exp_cred != 0);
    exp_mv   = (sb_q.size() > 0) && (sb_q[0].avail <= cyc);
    exp_md   = exp_mv ? sb_q[0].data : '0;
    occ = 0;
    foreach (sb_q[i]) if (sb_q[i].avail <= cyc) occ++;
    check_eq("s_ready",    64'(bus.s_ready),        64'(exp_rdy));
    check_eq("m_valid",    64'(bus.m_valid),        64'(exp_mv));
    check_eq("m_data",     64'(bus.m_data),         64'(exp_md));
    check_eq("credits",    64'(bus.credits),        64'(exp_cred));
    check_eq("fifo_count", 64'(dut.u_fifo.count),   64'(occ));
    check_eq("dp_valid",   64'(bus.dp_valid),       64'(prev_accept));
    check_eq("dp_c_a0",    {bus.dp_c, bus.dp_a0},   {last_ops.c, last_ops.a0});
    check_eq("dp_b0_a1",   {bus.dp_b0, bus.dp_a1},  {last_ops.b0, last_ops.a1});
    check_eq("dp_b1",      64'(bus.dp_b1),          64'(last_ops.b1));
    if (int'(bus.credits) < min_credits) min_credits = int'(bus.credits);
    if (bus.m_valid && first_mv_cyc < 0) begin
      first_mv_cyc = cyc;
      first_md     = bus.m_data;
    end
    acc = bus.s_valid && exp_rdy;
    pp  = exp_mv && bus.m_ready;
    ops = {bus.s_c, bus.s_a0, bus.s_b0, bus.s_a1, bus.s_b1};
    @(posedge clock);
    if (pp) void'(sb_q.pop_front());
    if (acc) begin
      sb_q.push_back('{data: mac_ref(ops), avail: cyc + 2 + LAT});
      n_accepts++;
      last_ops = ops;
    end
    prev_accept = acc;
    cyc++;
    #1;
  endtask

  task automatic reset_values(input string pfx);
    check_eq({pfx, "_s_ready"},  64'(bus.s_ready),  64'(0));
    check_eq({pfx, "_m_valid"},  64'(bus.m_valid),  64'(0));
    check_eq({pfx, "_m_data"},   64'(bus.m_data),   64'(0));
    check_eq({pfx, "_credits"},  64'(bus.credits),  64'(FD));
    check_eq({pfx, "_dp_valid"}, 64'(bus.dp_valid), 64'(0));
    check_eq({pfx, "_dp_ops"},   {bus.dp_c, bus.dp_b1}, 64'(0));
  endtask

  task automatic latency_probe(input string tag, input logic fixed_val);
    int k;
    first_mv_cyc = -1;
    bus.m_ready  = 1'b1;
    if (fixed_val)
      set_tuple(32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000, 32'h3F000000);
    else
      rand_tuple();
    bus.s_valid = 1'b1;
    k = cyc;
    tick();
    bus.s_valid = 1'b0;
    repeat (30) tick();
    check_eq({tag, "_latency"}, 64'(first_mv_cyc - k), 64'(20));
    if (fixed_val) check_eq({tag, "_value"}, 64'(first_md), 64'(32'h41100000));
  endtask

  initial begin
    int start;
    areset      = 1'b1;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
    set_tuple('0, '0, '0, '0, '0);
    min_credits  = FD;
    first_mv_cyc = -1;
    repeat (3) tick();
    reset_values("rst");
    areset = 1'b0;

    // Single tuple: 1 + 2*3 + 4*0.5 = 9.0
    latency_probe("single", 1'b1);

    // Full-rate burst
    min_credits = FD;
    start = n_accepts;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      rand_tuple();
      bus.s_valid = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (30) tick();
    check_eq("burst_accepts", 64'(n_accepts - start), 64'(100));
    check_eq("burst_min_credits_ge_11", 64'(min_credits >= 11), 64'(1));

    // Backpressure: credits run out at exactly FIFO_DEPTH tuples
    bus.m_ready = 1'b0;
    start = n_accepts;
    for (int i = 0; i < 60; i++) begin
      rand_tuple();
      bus.s_valid = 1'b1;
      tick();
    end
    check_eq("bp_accepts",   64'(n_accepts - start), 64'(FD));
    check_eq("bp_count",     64'(dut.u_fifo.count),  64'(FD));
    check_eq("bp_s_ready",   64'(bus.s_ready),       64'(0));
    bus.m_ready = 1'b1;
    tick();
    bus.m_ready = 1'b0;
    start = n_accepts;
    repeat (5) tick();
    check_eq("bp_one_more", 64'(n_accepts - start), 64'(1));

    // Accept and pop together while credits = 1
    bus.m_ready = 1'b1;
    tick();
    check_eq("c1_credits_before", 64'(bus.credits), 64'(1));
    tick();
    check_eq("c1_credits_hold",   64'(bus.credits), 64'(1));
    bus.s_valid = 1'b0;
    repeat (60) tick();

    // Random stress
    for (int i = 0; i < 10000; i++) begin
      bus.s_valid = ($urandom_range(0, 3) != 0);
      bus.m_ready = ($urandom_range(0, 2) != 0);
      rand_tuple();
      tick();
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    repeat (60) tick();
    check_eq("stress_drained_mv",  64'(bus.m_valid), 64'(0));
    check_eq("stress_drained_cr",  64'(bus.credits), 64'(FD));

    // Reset with 10 tuples in flight and 5 buffered
    bus.m_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      rand_tuple();
      bus.s_valid = 1'b1;
      tick();
    end
    bus.s_valid = 1'b0;
    repeat (9) tick();
    check_eq("mid_count_before", 64'(dut.u_fifo.count), 64'(5));
    check_eq("mid_credits_before", 64'(bus.credits), 64'(FD - 15));
    #2;
    areset = 1'b1;
    #1;
    reset_values("mid");
    check_eq("mid_count", 64'(dut.u_fifo.count), 64'(0));
    repeat (2) tick();
    areset = 1'b0;
    bus.m_ready  = 1'b1;
    first_mv_cyc = -1;
    repeat (40) tick();
    check_eq("mid_no_stale", 64'(first_mv_cyc), 64'(-1));
    latency_probe("post_rst", 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
